// File: rtl/alu_defs.sv
// Shared opcode, FSM-state and width definitions for the ALU execute stage.
package alu_defs;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;

    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_OR  = 3'b001;
    localparam logic [2:0] ALU_OP_ADD = 3'b010;
    localparam logic [2:0] ALU_OP_SUB = 3'b011;
    localparam logic [2:0] ALU_OP_SLT = 3'b100;
    localparam logic [2:0] ALU_OP_XOR = 3'b101;
    localparam logic [2:0] ALU_OP_SLL = 3'b110;
    localparam logic [2:0] ALU_OP_SRL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: logic slices plus a shared 33-bit adder for ADD/SUB/SLT.
module alu_comb import alu_defs::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             ovf
);
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic             w_sub_like;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf_raw;

    and32 #(.W(WIDTH)) u_and (.a(a), .b(b), .y(w_and));
    or32  #(.W(WIDTH)) u_or  (.a(a), .b(b), .y(w_or));

    // SUB and SLT share the A + ~B + 1 path
    assign w_sub_like = (op == ALU_OP_SUB) || (op == ALU_OP_SLT);
    assign w_b_eff    = w_sub_like ? ~b : b;
    assign w_sum      = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub_like};
    assign w_ovf_raw  = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        res   = a;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            ALU_OP_AND: res = w_and;
            ALU_OP_OR:  res = w_or;
            ALU_OP_ADD, ALU_OP_SUB: begin
                res   = w_sum[WIDTH-1:0];
                carry = w_sum[WIDTH];
                ovf   = w_ovf_raw;
            end
            ALU_OP_SLT: res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf_raw};
            ALU_OP_XOR: res = a ^ b;
            // Non-zero shifts go through the iterative shifter; a zero shift is a pass-through
            ALU_OP_SLL, ALU_OP_SRL: res = a;
            default: res = a;
        endcase
    end
endmodule

// File: rtl/and32.sv
// Bitwise AND slice.
module and32 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        assign y[gi] = a[gi] & b[gi];
    end
endmodule

// File: rtl/or32.sv
// Bitwise OR slice.
module or32 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        assign y[gi] = a[gi] | b[gi];
    end
endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: handshake in, one-cycle ALU or bit-serial shift, result held until writeback accepts.
module alu_exec_unit import alu_defs::*; #(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             busy
);
    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_res;
    logic               r_zero;
    logic               r_carry;
    logic               r_ovf;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_carry;
    logic               w_alu_ovf;
    logic [WIDTH-1:0]   w_shifted;
    logic               w_in_shift;

    alu_comb #(.WIDTH(WIDTH)) u_alu (
        .a     (r_a),
        .b     (r_b),
        .op    (r_op),
        .res   (w_alu_res),
        .carry (w_alu_carry),
        .ovf   (w_alu_ovf)
    );

    assign w_in_shift = ((op == ALU_OP_SLL) || (op == ALU_OP_SRL)) && (B[SHAMT_W-1:0] != '0);
    assign w_shifted  = (r_op == ALU_OP_SRL) ? (r_a >> 1) : (r_a << 1);

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_state_next = w_in_shift ? S_SHIFT : S_CALC;
            end
            S_CALC:  w_state_next = S_DONE;
            // One extra SHIFT cycle with the counter at zero registers the result
            S_SHIFT: if (r_cnt == '0) w_state_next = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_a   <= A;
                    r_b   <= B;
                    r_op  <= op;
                    r_cnt <= B[SHAMT_W-1:0];
                end
                S_CALC: begin
                    r_res   <= w_alu_res;
                    r_zero  <= (w_alu_res == '0);
                    r_carry <= w_alu_carry;
                    r_ovf   <= w_alu_ovf;
                end
                S_SHIFT: if (r_cnt != '0) begin
                    r_a   <= w_shifted;
                    r_cnt <= r_cnt - 1'b1;
                end else begin
                    r_res   <= r_a;
                    r_zero  <= (r_a == '0);
                    r_carry <= 1'b0;
                    r_ovf   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign res   = r_res;
    assign zero  = r_zero;
    assign carry = r_carry;
    assign ovf   = r_ovf;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed checks of alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [2:0]  op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] res;
    logic        zero, carry, ovf, busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    alu_exec_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .zero(zero), .carry(carry), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer arithmetic over the opcode definitions
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                                  output logic [31:0] r, output logic c, output logic v, output int lat);
        longint sa, sb, t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; c = 1'b0; v = 1'b0; t = 0;
        case (o)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin
                r = a + b;
                c = (longint'(a) + longint'(b)) > 64'sd4294967295;
                t = sa + sb;
                v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            3'd3: begin
                r = a - b;
                c = (a >= b);
                t = sa - sb;
                v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            3'd4: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd5: r = a ^ b;
            3'd6: r = a << b[4:0];
            default: r = a >> b[4:0];
        endcase
        lat = (o >= 3'd6 && b[4:0] != 5'd0) ? int'(b[4:0]) + 2 : 2;
    endfunction

    // Issues one op and waits for out_valid; lat counts cycles from the accept cycle (=1) to out_valid
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o, input logic ordy,
                         output logic [31:0] r, output logic z, output logic c, output logic v,
                         output int lat, output logic busy_ok, output bit timed_out, output int acc_cyc);
        int guard = 0;
        r = 'x; z = 1'bx; c = 1'bx; v = 1'bx; lat = 0; busy_ok = 1'b1; timed_out = 1'b0; acc_cyc = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        if (!in_ready) begin
            timed_out = 1'b1;
            return;
        end
        A = a; B = b; op = o; in_valid = 1'b1; out_ready = ordy;
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            busy_ok &= busy;
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) timed_out = 1'b1;
        r = res; z = zero; c = carry; v = ovf;
        $display("op=%0d A=%08h B=%08h -> res=%08h z=%0b c=%0b v=%0b lat=%0d", o, a, b, r, z, c, v, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_err++; $display("FAIL reset_ctrl: got in_ready/out_valid/busy=%b, required 100", {in_ready, out_valid, busy});
        end
        n_vec++;
        if ({res, zero, carry, ovf} !== 35'd0) begin
            n_err++; $display("FAIL reset_data: got res=%08h z=%b c=%b v=%b, required all zero", res, zero, carry, ovf);
        end
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic [2:0]  o;
        logic [31:0] r;
        logic        z, c, v;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t tbl[$];
        logic [31:0] r; logic z, c, v, bok; int lat, ac; bit to;
        tbl.push_back('{32'hA5A5A5A5, 32'h5A5A5A5A, 3'b001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 2});
        tbl.push_back('{32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b0, 1'b0, 1'b1, 2});
        tbl.push_back('{32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b1, 1'b1, 1'b0, 2});
        tbl.push_back('{32'h00000005, 32'h00000007, 3'b011, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 2});
        tbl.push_back('{32'h00000007, 32'h00000005, 3'b011, 32'h00000002, 1'b0, 1'b1, 1'b0, 2});
        tbl.push_back('{32'hFFFFFFFF, 32'h00000001, 3'b100, 32'h00000001, 1'b0, 1'b0, 1'b0, 2});
        tbl.push_back('{32'h00000001, 32'hFFFFFFFF, 3'b100, 32'h00000000, 1'b1, 1'b0, 1'b0, 2});
        tbl.push_back('{32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 2});
        tbl.push_back('{32'h00000001, 32'h0000001F, 3'b110, 32'h80000000, 1'b0, 1'b0, 1'b0, 33});
        tbl.push_back('{32'h80000000, 32'h00000000, 3'b111, 32'h80000000, 1'b0, 1'b0, 1'b0, 2});
        tbl.push_back('{32'h80000000, 32'h00000004, 3'b111, 32'h08000000, 1'b0, 1'b0, 1'b0, 6});
        foreach (tbl[i]) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].o, 1'b1, r, z, c, v, lat, bok, to, ac);
            n_vec++;
            if (to || r !== tbl[i].r || z !== tbl[i].z || c !== tbl[i].c || v !== tbl[i].v || lat != tbl[i].lat || !bok) begin
                n_err++;
                $display("FAIL directed[%0d]: got res=%08h z=%b c=%b v=%b lat=%0d busy_ok=%b to=%0b, required res=%08h z=%b c=%b v=%b lat=%0d busy_ok=1",
                         i, r, z, c, v, lat, bok, to, tbl[i].r, tbl[i].z, tbl[i].c, tbl[i].v, tbl[i].lat);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
        logic [31:0] a, b, r, er; logic [2:0] o; logic z, c, v, ec, ev, bok; int lat, el, ac; bit to;
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            o = 3'($urandom_range(0, 7));
            if (o >= 3'd6 && $urandom_range(0, 4) == 0) b[4:0] = 5'd0;
            model(a, b, o, er, ec, ev, el);
            do_op(a, b, o, 1'b1, r, z, c, v, lat, bok, to, ac);
            n_vec++;
            if (to || r !== er || z !== (er == 32'd0) || c !== ec || v !== ev || lat != el) begin
                n_err++;
                $display("FAIL random[%0d] op=%0d A=%08h B=%08h: got res=%08h z=%b c=%b v=%b lat=%0d to=%0b, required res=%08h z=%b c=%b v=%b lat=%0d",
                         i, o, a, b, r, z, c, v, lat, to, er, (er == 32'd0), ec, ev, el);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r, er; logic z, c, v, ec, ev, bok; int lat, el, ac; bit to;
        model(32'h7FFFFFF0, 32'h00000020, 3'b010, er, ec, ev, el);
        do_op(32'h7FFFFFF0, 32'h00000020, 3'b010, 1'b0, r, z, c, v, lat, bok, to, ac);
        n_vec++;
        if (to || r !== er || c !== ec || v !== ev || lat != el) begin
            n_err++; $display("FAIL bp_result: got res=%08h c=%b v=%b lat=%0d, required res=%08h c=%b v=%b lat=%0d", r, c, v, lat, er, ec, ev, el);
        end
        for (int k = 0; k < 10; k++) begin
            A = $urandom; B = $urandom; op = 3'b000; in_valid = 1'b1;
            @(posedge clk); #1;
            n_vec++;
            if (res !== er || zero !== 1'b0 || carry !== ec || ovf !== ev || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got res=%08h z=%b c=%b v=%b in_ready=%b out_valid=%b, required res=%08h z=0 c=%b v=%b in_ready=0 out_valid=1",
                         k, res, zero, carry, ovf, in_ready, out_valid, er, ec, ev);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL bp_release: got in_ready=%b out_valid=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r; logic z, c, v, bok; int lat, ac; bit to, seen;
        int guard = 0;
        while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        A = 32'h1; B = 32'd20; op = 3'b110; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL abort_inflight: got busy=%b out_valid=%b, required 1 0", busy, out_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b0 || res !== 32'd0 || zero !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL abort_reset: got out_valid=%b res=%08h z=%b in_ready=%b busy=%b, required 0 00000000 0 1 0",
                              out_valid, res, zero, in_ready, busy);
        end
        rst = 1'b0;
        seen = 1'b0;
        repeat (25) begin @(posedge clk); #1; seen |= out_valid; end
        n_vec++;
        if (seen) begin
            n_err++; $display("FAIL abort_no_pulse: got out_valid pulse after abort, required none");
        end
        do_op(32'hFFFF0000, 32'h0F0F0F0F, 3'b101, 1'b1, r, z, c, v, lat, bok, to, ac);
        n_vec++;
        if (to || r !== 32'hF0F00F0F || z !== 1'b0 || c !== 1'b0 || v !== 1'b0 || lat != 2) begin
            n_err++; $display("FAIL abort_followup_xor: got res=%08h z=%b c=%b v=%b lat=%0d, required F0F00F0F 0 0 0 lat=2", r, z, c, v, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, r, er; logic [2:0] o; logic z, c, v, ec, ev, bok; int lat, el, ac, prev;
        bit to;
        prev = -1;
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom; o = 3'($urandom_range(0, 5));
            model(a, b, o, er, ec, ev, el);
            do_op(a, b, o, 1'b1, r, z, c, v, lat, bok, to, ac);
            n_vec++;
            if (to || r !== er || c !== ec || v !== ev) begin
                n_err++; $display("FAIL b2b_result[%0d]: got res=%08h c=%b v=%b, required res=%08h c=%b v=%b", i, r, c, v, er, ec, ev);
            end
            if (prev >= 0) begin
                n_vec++;
                if (ac - prev != 3) begin
                    n_err++; $display("FAIL b2b_spacing[%0d]: got %0d cycles between accepts, required 3", i, ac - prev);
                end
            end
            prev = ac;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
